sprite_drawer: RTL and testbench
================================

# sprite_drawer

Consumer end of the player/enemy position interface. It takes the `move` pulse and top-left coordinates produced by a motion controller and drives the VGA adapter's pixel-plot port. It erases the square sprite at its previously drawn position, then draws it at the new position, one pixel per clock. One instance sits between each motion controller and the shared VGA plot mux.

## Interface
Parameters:
- `SCREEN_W`, 160: visible width in pixels; pixels with x ≥ SCREEN_W are clipped.
- `SCREEN_H`, 120: visible height in pixels; pixels with y ≥ SCREEN_H are clipped.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `move`  in  1  single-cycle request: sprite now at `pos_x`/`pos_y`.
- `pos_x`  in  8  new top-left x, sampled when a request is accepted.
- `pos_y`  in  7  new top-left y, sampled when a request is accepted.
- `width`  in  3  sprite side in pixels, sampled with the position; 0 is treated as 1.
- `fg_colour`  in  3  sprite colour, sampled with the position.
- `bg_colour`  in  3  erase colour, sampled with the position.
- `x`  out  8  pixel x to the VGA adapter.
- `y`  out  7  pixel y to the VGA adapter.
- `colour`  out  3  pixel colour to the VGA adapter.
- `plot`  out  1  write enable for the current `x`/`y`/`colour`.
- `busy`  out  1  high whenever not in IDLE.
- `done`  out  1  one-cycle pulse when a redraw completes.

## Operation
- States: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - On `move`, or when a request is pending, capture `pos_x`, `pos_y`, `width`, `fg_colour` and `bg_colour` as the "new" set.
  - If `old_valid`, go to ERASE; otherwise go to DRAW.
- ERASE: scan the old square row-major. dx runs 0..w_old-1 (inner loop) and dy runs 0..w_old-1 (outer loop). Output `x`=old_x+dx, `y`=old_y+dy, `colour`=old bg_colour. After the last pixel, go to DRAW.
- DRAW: same scan over the new square with the new fg_colour. After the last pixel:
  - copy the new set into the old set;
  - set `old_valid`=1;
  - go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Arithmetic:
  - x+dx is computed at 9 bits and y+dy at 8 bits.
  - If the result is ≥ SCREEN_W or ≥ SCREEN_H, that cycle has `plot`=0, but the scan still advances. Clipping never shortens the pass.
- Pending request:
  - A `move` arriving while `busy` sets a one-deep `pending` flag. Position is not sampled at that moment.
  - A further `move` while `pending` is already set is absorbed.
  - On the return to IDLE, `pending` is cleared and the current `pos_*` inputs are captured as a fresh request, with no wait for another `move`.
- `move` in the same cycle as DONE→IDLE sets `pending`, so the request is not lost.

## Timing
- Reset values: state IDLE, `plot`=0, `busy`=0, `done`=0, `x`=0, `y`=0, `colour`=0, `old_valid`=0, `pending`=0. All counters are 0.
- Reset mid-pass aborts immediately. No further pixels are plotted, and the next draw skips ERASE.
- `x`, `y`, `colour` and `plot` are registered and change together.
- A request sampled on edge T gives the first pixel valid from T+1.
- A full redraw occupies w_old² (ERASE) + w_new² (DRAW) cycles, then 1 DONE cycle. `busy` is high for the entire span.
- Idle-to-idle latency:
  - width 3 with a prior draw: 9+9+1 = 19 cycles;
  - width 3 as the first draw: 10 cycles.
- Outside ERASE/DRAW, `plot`=0.

## Test plan
- **First draw:** after reset, `move` with pos=(80,115), width=3, fg=3'b111. Required: exactly 9 plots, row-major (80,115)(81,115)(82,115)(80,116)…(82,117), all colour 7. `done` 10 cycles after the request. No erase.
- **Redraw:** then `move` with pos=(81,115), bg=0. Required: 9 plots erasing (80..82,115..117) with colour 0, then 9 plots drawing (81..83,115..117) with colour 7. `done` 19 cycles after the request.
- **Clipping:** pos=(158,118), width=3. Required: 9 scan cycles, with `plot`=1 only for (158,118), (159,118), (158,119), (159,119).
- **Busy request:** `move` mid-DRAW with pos changed to (10,10), plus a second `move` while pending. Required: exactly one extra redraw after `done`, at (10,10).
- **Reset mid-pass:** assert `reset` during ERASE. Required: `plot`/`busy` low immediately. The next `move` does DRAW only.
- **Width 0:** width=0. Required: a single 1×1 pixel is plotted.

Source files
------------

// File: rtl/sprite_drawer.sv
// Erases a square sprite at its last drawn position, then draws it at the newly
// requested one, emitting one pixel write per clock toward the VGA plot port.
module sprite_drawer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move,
    input  logic [7:0] pos_x,
    input  logic [6:0] pos_y,
    input  logic [2:0] width,
    input  logic [2:0] fg_colour,
    input  logic [2:0] bg_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    localparam logic [8:0] SCREEN_W9 = 9'(SCREEN_W);
    localparam logic [7:0] SCREEN_H8 = 8'(SCREEN_H);

    state_t     state_q, state_d;
    logic [2:0] dx_q, dx_d, dy_q, dy_d;
    logic [7:0] new_x_q, new_x_d, old_x_q, old_x_d;
    logic [6:0] new_y_q, new_y_d, old_y_q, old_y_d;
    logic [2:0] new_w_q, new_w_d, old_w_q, old_w_d;
    logic [2:0] new_fg_q, new_fg_d, new_bg_q, new_bg_d, old_bg_q, old_bg_d;
    logic       old_valid_q, old_valid_d, pending_q, pending_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d, busy_q, done_q;

    logic [2:0] w_cur, w_m1;
    logic       last_px;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [2:0] base_col;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       scanning_d;

    assign w_cur   = (state_q == ERASE) ? old_w_q : new_w_q;
    assign w_m1    = w_cur - 3'd1;
    assign last_px = (dx_q == w_m1) && (dy_q == w_m1);

    always_comb begin
        state_d     = state_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        new_x_d     = new_x_q;
        new_y_d     = new_y_q;
        new_w_d     = new_w_q;
        new_fg_d    = new_fg_q;
        new_bg_d    = new_bg_q;
        old_x_d     = old_x_q;
        old_y_d     = old_y_q;
        old_w_d     = old_w_q;
        old_bg_d    = old_bg_q;
        old_valid_d = old_valid_q;
        pending_d   = pending_q;

        case (state_q)
            IDLE: begin
                if (move || pending_q) begin
                    new_x_d   = pos_x;
                    new_y_d   = pos_y;
                    new_w_d   = (width == 3'd0) ? 3'd1 : width;
                    new_fg_d  = fg_colour;
                    new_bg_d  = bg_colour;
                    pending_d = 1'b0;
                    dx_d      = 3'd0;
                    dy_d      = 3'd0;
                    state_d   = old_valid_q ? ERASE : DRAW;
                end
            end
            ERASE, DRAW: begin
                if (move) pending_d = 1'b1;
                if (last_px) begin
                    dx_d = 3'd0;
                    dy_d = 3'd0;
                    if (state_q == ERASE) begin
                        state_d = DRAW;
                    end else begin
                        old_x_d     = new_x_q;
                        old_y_d     = new_y_q;
                        old_w_d     = new_w_q;
                        old_bg_d    = new_bg_q;
                        old_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end else if (dx_q == w_m1) begin
                    dx_d = 3'd0;
                    dy_d = dy_q + 3'd1;
                end else begin
                    dx_d = dx_q + 3'd1;
                end
            end
            default: begin
                if (move) pending_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Pixel outputs are computed from the next counters so they line up with the state they belong to.
    always_comb begin
        scanning_d = (state_d == ERASE) || (state_d == DRAW);
        if (state_d == ERASE) begin
            base_x   = old_x_q;
            base_y   = old_y_q;
            base_col = old_bg_q;
        end else begin
            base_x   = new_x_d;
            base_y   = new_y_d;
            base_col = new_fg_d;
        end
        sum_x    = {1'b0, base_x} + {6'd0, dx_d};
        sum_y    = {1'b0, base_y} + {5'd0, dy_d};
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        if (scanning_d) begin
            x_d      = sum_x[7:0];
            y_d      = sum_y[6:0];
            colour_d = base_col;
            plot_d   = (sum_x < SCREEN_W9) && (sum_y < SCREEN_H8);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dx_q        <= 3'd0;
            dy_q        <= 3'd0;
            new_x_q     <= 8'd0;
            new_y_q     <= 7'd0;
            new_w_q     <= 3'd0;
            new_fg_q    <= 3'd0;
            new_bg_q    <= 3'd0;
            old_x_q     <= 8'd0;
            old_y_q     <= 7'd0;
            old_w_q     <= 3'd0;
            old_bg_q    <= 3'd0;
            old_valid_q <= 1'b0;
            pending_q   <= 1'b0;
            x_q         <= 8'd0;
            y_q         <= 7'd0;
            colour_q    <= 3'd0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            new_x_q     <= new_x_d;
            new_y_q     <= new_y_d;
            new_w_q     <= new_w_d;
            new_fg_q    <= new_fg_d;
            new_bg_q    <= new_bg_d;
            old_x_q     <= old_x_d;
            old_y_q     <= old_y_d;
            old_w_q     <= old_w_d;
            old_bg_q    <= old_bg_d;
            old_valid_q <= old_valid_d;
            pending_q   <= pending_d;
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            plot_q      <= plot_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_sprite_drawer.sv
// Directed bench for sprite_drawer: checks plotted pixel sequences, done latency,
// clipping, queued requests, reset abort and zero width against hand-built lists.
module tb_sprite_drawer;

    logic       clk = 1'b0;
    logic       reset;
    logic       move;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic [2:0] width;
    logic [2:0] fg_colour;
    logic [2:0] bg_colour;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int got_q[$];
    int exp_q[$];
    int lat_q[$];

    sprite_drawer #(.SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk(clk), .reset(reset), .move(move),
        .pos_x(pos_x), .pos_y(pos_y), .width(width),
        .fg_colour(fg_colour), .bg_colour(bg_colour),
        .x(x), .y(y), .colour(colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected plots of one square scan, clipped to 160x120.
    task automatic push_sq(input int bx, input int by, input int w, input int col);
        int ww;
        ww = (w == 0) ? 1 : w;
        for (int dy = 0; dy < ww; dy++)
            for (int dx = 0; dx < ww; dx++)
                if (bx + dx < 160 && by + dy < 120)
                    exp_q.push_back(((bx + dx) << 10) | ((by + dy) << 3) | col);
    endtask

    task automatic compare_px(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_px%0d", tag, i), got_q[i], exp_q[i]);
        $display("%s: %0d plots observed, %0d expected", tag, got_q.size(), exp_q.size());
        exp_q.delete();
    endtask

    // Issues one request and records plots and done latencies (cycles after the request cycle).
    task automatic run_req(input int px, input int py, input int w, input int fg, input int bg,
                           input int inj_a, input int inj_b, input int ix, input int iy,
                           input int n_done);
        int c;
        got_q.delete();
        lat_q.delete();
        @(negedge clk);
        pos_x = 8'(px); pos_y = 7'(py); width = 3'(w);
        fg_colour = 3'(fg); bg_colour = 3'(bg);
        move = 1'b1;
        c = 0;
        while (lat_q.size() < n_done && c < 300) begin
            @(negedge clk);
            c++;
            if (plot) got_q.push_back(int'({x, y, colour}));
            if (done) lat_q.push_back(c);
            move = (c == inj_a) || (c == inj_b);
            if (move) begin
                pos_x = 8'(ix);
                pos_y = 7'(iy);
            end
        end
        move = 1'b0;
        if (lat_q.size() < n_done) check("done_timeout", lat_q.size(), n_done);
    endtask

    initial begin
        int idle_busy;
        reset = 1'b1; move = 1'b0;
        pos_x = '0; pos_y = '0; width = '0; fg_colour = '0; bg_colour = '0;
        repeat (2) @(negedge clk);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_colour", int'(colour), 0);
        reset = 1'b0;
        @(negedge clk);

        // First draw: no erase.
        run_req(80, 115, 3, 7, 0, -1, -1, 0, 0, 1);
        push_sq(80, 115, 3, 7);
        compare_px("first");
        check("first_lat", lat_q[0], 10);

        // Redraw one pixel right.
        run_req(81, 115, 3, 7, 0, -1, -1, 0, 0, 1);
        push_sq(80, 115, 3, 0);
        push_sq(81, 115, 3, 7);
        compare_px("redraw");
        check("redraw_lat", lat_q[0], 19);

        // Clipping at bottom-right corner; full scan length kept.
        run_req(158, 118, 3, 5, 2, -1, -1, 0, 0, 1);
        push_sq(81, 115, 3, 0);
        push_sq(158, 118, 3, 5);
        compare_px("clip");
        check("clip_lat", lat_q[0], 19);

        // Two moves during DRAW collapse into one extra redraw at (10,10).
        run_req(20, 20, 2, 6, 1, 11, 13, 10, 10, 2);
        push_sq(158, 118, 3, 2);
        push_sq(20, 20, 2, 6);
        push_sq(20, 20, 2, 1);
        push_sq(10, 10, 2, 6);
        compare_px("pending");
        check("pending_lat0", lat_q[0], 14);
        check("pending_lat1", lat_q[1], 24);
        idle_busy = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy) idle_busy++;
        end
        check("pending_no_third", idle_busy, 0);

        // Reset during ERASE aborts; following draw skips erase.
        @(negedge clk);
        pos_x = 8'd50; pos_y = 7'd50; width = 3'd3; fg_colour = 3'd3; bg_colour = 3'd4;
        move = 1'b1;
        @(negedge clk);
        move = 1'b0;
        check("abort_pre_plot", int'(plot), 1);
        check("abort_pre_colour", int'(colour), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_plot", int'(plot), 0);
        check("abort_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        run_req(30, 40, 2, 4, 5, -1, -1, 0, 0, 1);
        push_sq(30, 40, 2, 4);
        compare_px("after_reset");
        check("after_reset_lat", lat_q[0], 5);

        // Width 0 behaves as 1x1.
        run_req(5, 6, 0, 1, 0, -1, -1, 0, 0, 1);
        push_sq(30, 40, 2, 5);
        push_sq(5, 6, 1, 1);
        compare_px("width0");
        check("width0_lat", lat_q[0], 6);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
